// File: rtl/multicycle_main_control.sv
// ============================================================================
// multicycle_main_control
//
// Main control FSM of the multicycle MIPS datapath. Walks each instruction
// through fetch, decode, execute, memory and writeback, and drives every
// datapath enable and mux select plus the 2-bit alu_op into the ALU control
// decoder. Memory accesses stall on mem_ready. Retired instructions are
// counted.
//
// State table (encoding | name       | meaning)
//   0  | FETCH      | read instruction at PC, PC+4, load IR on mem_ready
//   1  | DECODE     | read registers, precompute branch target, dispatch
//   2  | MEM_ADDR   | ALUOut = A + sign-ext imm (lw/sw address)
//   3  | MEM_READ   | read data memory at ALUOut, wait for mem_ready
//   4  | MEM_WB     | rt <= MDR
//   5  | MEM_WRITE  | write B to data memory at ALUOut, wait for mem_ready
//   6  | EXECUTE    | R-type ALU operation A op B
//   7  | R_COMPLETE | rd <= ALUOut
//   8  | BRANCH     | compare A-B, PC <= ALUOut if zero
//   9  | JUMP       | PC <= jump target
//  10  | ADDI_EXEC  | ALUOut = A + sign-ext imm
//  11  | ADDI_WB    | rt <= ALUOut
//  12-15 unused; recover to FETCH with all enables low
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high
//   opcode        IR[31:26]
//   mem_ready     memory handshake, access completes on a cycle it is 1
//   pc_write      unconditional PC write enable
//   pc_write_cond PC write when ALU zero (branch)
//   i_or_d        memory address select: 0=PC, 1=ALUOut
//   mem_read      memory read request
//   mem_write     memory write request
//   ir_write      instruction register load
//   mem_to_reg    register write data: 0=ALUOut, 1=MDR
//   reg_dst       destination register: 0=rt, 1=rd
//   reg_write     register file write enable
//   alu_src_a     0=PC, 1=A
//   alu_src_b     00=B, 01=4, 10=sext imm, 11=sext imm<<2
//   alu_op        00=add, 01=sub, 10=use funct
//   pc_source     00=ALU result, 01=ALUOut, 10=jump target
//   illegal_op    one-cycle pulse on unsupported opcode (in DECODE)
//   state_dbg     current state encoding
//   instr_count   retired-instruction counter, wraps
// ============================================================================
module multicycle_main_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH      = 4'd0,
        DECODE     = 4'd1,
        MEM_ADDR   = 4'd2,
        MEM_READ   = 4'd3,
        MEM_WB     = 4'd4,
        MEM_WRITE  = 4'd5,
        EXECUTE    = 4'd6,
        R_COMPLETE = 4'd7,
        BRANCH     = 4'd8,
        JUMP       = 4'd9,
        ADDI_EXEC  = 4'd10,
        ADDI_WB    = 4'd11
    } state_t;

    state_t state;
    state_t state_n;

    // Ungated enables; the reset gate below is applied on the way out so a
    // reset landing mid-instruction can never leak a write.
    logic pc_write_raw;
    logic pc_write_cond_raw;
    logic mem_read_raw;
    logic mem_write_raw;
    logic ir_write_raw;
    logic reg_write_raw;
    logic illegal_raw;
    logic retire;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_n           = state;
        pc_write_raw      = 1'b0;
        pc_write_cond_raw = 1'b0;
        mem_read_raw      = 1'b0;
        mem_write_raw     = 1'b0;
        ir_write_raw      = 1'b0;
        reg_write_raw     = 1'b0;
        illegal_raw       = 1'b0;
        retire            = 1'b0;
        i_or_d            = 1'b0;
        mem_to_reg        = 1'b0;
        reg_dst           = 1'b0;
        alu_src_a         = 1'b0;
        alu_src_b         = SRCB_B;
        alu_op            = ALUOP_ADD;
        pc_source         = PCSRC_ALU;

        case (state)
            FETCH: begin
                mem_read_raw = 1'b1;
                alu_src_b    = SRCB_FOUR;
                alu_op       = ALUOP_ADD;
                pc_source    = PCSRC_ALU;
                // IR load and PC+4 commit only on the cycle the read completes
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
                state_n      = mem_ready ? DECODE : FETCH;
            end

            DECODE: begin
                alu_src_b = SRCB_BOFF;
                alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_n = MEM_ADDR;
                    OP_RTYPE:     state_n = EXECUTE;
                    OP_BEQ:       state_n = BRANCH;
                    OP_J:         state_n = JUMP;
                    OP_ADDI:      state_n = ADDI_EXEC;
                    default: begin
                        state_n     = FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end

            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_n   = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end

            MEM_READ: begin
                mem_read_raw = 1'b1;
                i_or_d       = 1'b1;
                state_n      = mem_ready ? MEM_WB : MEM_READ;
            end

            MEM_WB: begin
                reg_dst       = 1'b0;
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_n       = FETCH;
            end

            MEM_WRITE: begin
                // Request held for the whole wait; retires on completion
                mem_write_raw = 1'b1;
                i_or_d        = 1'b1;
                retire        = mem_ready;
                state_n       = mem_ready ? FETCH : MEM_WRITE;
            end

            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_B;
                alu_op    = ALUOP_FUNCT;
                state_n   = R_COMPLETE;
            end

            R_COMPLETE: begin
                reg_dst       = 1'b1;
                mem_to_reg    = 1'b0;
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_n       = FETCH;
            end

            BRANCH: begin
                alu_src_a         = 1'b1;
                alu_src_b         = SRCB_B;
                alu_op            = ALUOP_SUB;
                pc_write_cond_raw = 1'b1;
                pc_source         = PCSRC_ALUOUT;
                retire            = 1'b1;
                state_n           = FETCH;
            end

            JUMP: begin
                pc_write_raw = 1'b1;
                pc_source    = PCSRC_JUMP;
                retire       = 1'b1;
                state_n      = FETCH;
            end

            ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_n   = ADDI_WB;
            end

            ADDI_WB: begin
                reg_dst       = 1'b0;
                mem_to_reg    = 1'b0;
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_n       = FETCH;
            end

            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Reset gating of enables
    // ------------------------------------------------------------------
    always_comb begin
        pc_write      = pc_write_raw      & ~reset;
        pc_write_cond = pc_write_cond_raw & ~reset;
        mem_read      = mem_read_raw      & ~reset;
        mem_write     = mem_write_raw     & ~reset;
        ir_write      = ir_write_raw      & ~reset;
        reg_write     = reg_write_raw     & ~reset;
        illegal_op    = illegal_raw       & ~reset;
    end

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // Retired-instruction counter, reset wins over increment
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM of the multicycle MIPS datapath.
- Sits directly upstream of the ALU control decoder and drives its 2-bit ALU operation input.
- Sequences fetch, decode, execute, memory and writeback from the 6-bit instruction opcode, and generates every datapath enable and mux select.
- Stalls on a memory-ready handshake. Counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  instruction opcode (IR[31:26]); IR only changes in FETCH
mem_ready  in  1  memory handshake; access completes on a cycle where it is 1
pc_write  out  1  unconditional PC write enable
pc_write_cond  out  1  PC write if ALU zero (branch)
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
mem_to_reg  out  1  register write data: 0=ALUOut, 1=MDR
reg_dst  out  1  destination register: 0=rt, 1=rd
reg_write  out  1  register file write enable
alu_src_a  out  1  0=PC, 1=register A
alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  2  to ALU control: 00=add, 01=sub, 10=use funct
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
illegal_op  out  1  one-cycle pulse on unsupported opcode
state_dbg  out  4  current state encoding
instr_count  out  CNT_W  retired-instruction counter

Behaviour:
- Moore FSM, one 4-bit state register.
- Outputs are combinational from state, except the mem_ready gating noted below. Any signal not listed for a state is 0.
- Reset:
  - Next edge with reset=1 forces state to FETCH and instr_count to 0.
  - While reset=1, pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write and illegal_op are forced to 0.
  - Reset mid-instruction aborts it with no further writes.
- States, encoding, outputs and transitions:
  - FETCH=0: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00, ir_write=mem_ready, pc_write=mem_ready. Go to DECODE when mem_ready=1, else stay.
  - DECODE=1: alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
    - 35 (lw) or 43 (sw) -> MEM_ADDR
    - 0 (R-type) -> EXECUTE
    - 4 (beq) -> BRANCH
    - 2 (j) -> JUMP
    - 8 (addi) -> ADDI_EXEC
    - anything else -> FETCH, with illegal_op=1 this cycle only and no count increment.
  - MEM_ADDR=2: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_READ if opcode=35, else MEM_WRITE.
  - MEM_READ=3: mem_read=1, i_or_d=1. Go to MEM_WB on mem_ready=1, else hold.
  - MEM_WB=4: reg_dst=0, mem_to_reg=1, reg_write=1. Go to FETCH.
  - MEM_WRITE=5: mem_write=1, i_or_d=1, held for the whole wait. Go to FETCH on mem_ready=1.
  - EXECUTE=6: alu_src_a=1, alu_src_b=00, alu_op=10. Go to R_COMPLETE.
  - R_COMPLETE=7: reg_dst=1, mem_to_reg=0, reg_write=1. Go to FETCH.
  - BRANCH=8: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Go to FETCH.
  - JUMP=9: pc_write=1, pc_source=10. Go to FETCH.
  - ADDI_EXEC=10: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDI_WB.
  - ADDI_WB=11: reg_dst=0, mem_to_reg=0, reg_write=1. Go to FETCH.
  - Encodings 12-15 are unreachable; if entered, go to FETCH with all enables 0.
- instr_count:
  - Increments by 1 on the edge leaving MEM_WB, MEM_WRITE (with mem_ready), R_COMPLETE, BRANCH, JUMP or ADDI_WB.
  - Wraps modulo 2^CNT_W.
  - Reset has priority over increment.
- Latency with mem_ready held at 1, cycles FETCH to next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- mem_ready is ignored in states that make no memory access.

Test Plan:
- Reset then mem_ready=1, opcode=0 -> states 0,1,6,7,0. alu_op=10 in EXECUTE. reg_write=1 and reg_dst=1 in R_COMPLETE. instr_count=1.
- opcode=35, mem_ready low for 3 cycles in FETCH and 2 in MEM_READ -> FETCH holds mem_read=1 with pc_write=ir_write=0 until ready. Path 0,1,2,3,4,0. mem_to_reg=1 in MEM_WB. Total 10 cycles.
- opcode=43, mem_ready=1 -> path 0,1,2,5,0. mem_write=1 and i_or_d=1 exactly one cycle. reg_write never 1.
- opcode=4 then opcode=2 -> BRANCH shows alu_op=01, pc_write_cond=1, pc_source=01. JUMP shows pc_write=1, pc_source=10. instr_count increments by 2.
- opcode=63 -> illegal_op high exactly in the DECODE cycle, returns to FETCH, instr_count unchanged.
- reset asserted while in MEM_WRITE with mem_ready=0 -> next cycle state=0, mem_write=0, instr_count=0. No write enable high while reset=1.
